// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the PI memory master and the memory arbiter.
// Writes are acked once queued; reads wait until every queued write has drained.
module mem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         up_request,
  output logic                         up_ack,
  input  logic                         up_write,
  input  logic [1:0]                   up_wmask,
  input  logic [31:0]                  up_address,
  input  logic [15:0]                  up_wdata,
  output logic [15:0]                  up_rdata,
  output logic                         dn_request,
  input  logic                         dn_ack,
  output logic                         dn_write,
  output logic [1:0]                   dn_wmask,
  output logic [31:0]                  dn_address,
  output logic [15:0]                  dn_wdata,
  input  logic [15:0]                  dn_rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    READ_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t          state_r, state_next_s;
  logic [1:0]      wmask_mem_r [DEPTH];
  logic [31:0]     addr_mem_r  [DEPTH];
  logic [15:0]     wdata_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_next_s;
  logic            empty_r, up_ack_r, dn_request_r, dn_write_r;
  logic [1:0]      dn_wmask_r;
  logic [31:0]     dn_address_r;
  logic [15:0]     dn_wdata_r, up_rdata_r;
  logic            push_s, pop_s, rd_done_s, rd_pending_s, load_wr_s, load_rd_s;
  logic            bypass_s;

  assign push_s       = up_request && up_write && !up_ack_r && (count_r < DEPTH_C);
  assign pop_s        = (state_r == WRITE) && dn_ack;
  assign rd_done_s    = (state_r == READ) && dn_ack;
  assign rd_pending_s = up_request && !up_write && !up_ack_r && (count_r == CW'(0));
  // An empty FIFO lets a write accepted this cycle go straight to the dn_* fields.
  assign bypass_s     = (count_r == CW'(0));

  // Downstream sequencer next-state and load decisions.
  always_comb begin
    state_next_s = state_r;
    load_wr_s    = 1'b0;
    load_rd_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if ((count_r != CW'(0)) || push_s) begin
          state_next_s = WRITE;
          load_wr_s    = 1'b1;
        end else if (rd_pending_s) begin
          state_next_s = READ;
          load_rd_s    = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        if (dn_ack) begin
          state_next_s = GAP;
        end else begin
          state_next_s = WRITE;
        end
      end
      READ: begin
        if (dn_ack) begin
          state_next_s = READ_DONE;
        end else begin
          state_next_s = READ;
        end
      end
      READ_DONE: state_next_s = GAP;
      GAP:       state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
  end

  // Occupancy update from push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Posted-write storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      wmask_mem_r[wr_ptr_r] <= up_wmask;
      addr_mem_r[wr_ptr_r]  <= up_address;
      wdata_mem_r[wr_ptr_r] <= up_wdata;
    end
  end

  // State register, pointers, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= PW'(0);
      rd_ptr_r     <= PW'(0);
      count_r      <= CW'(0);
      empty_r      <= 1'b1;
      up_ack_r     <= 1'b0;
      up_rdata_r   <= 16'h0000;
      dn_request_r <= 1'b0;
      dn_write_r   <= 1'b0;
      dn_wmask_r   <= 2'b00;
      dn_address_r <= 32'h0000_0000;
      dn_wdata_r   <= 16'h0000;
    end else begin
      state_r  <= state_next_s;
      count_r  <= count_next_s;
      empty_r  <= (count_next_s == CW'(0)) && (state_next_s == IDLE);
      up_ack_r <= push_s || rd_done_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (rd_done_s) begin
        up_rdata_r <= dn_rdata;
      end
      if (load_wr_s) begin
        dn_request_r <= 1'b1;
        dn_write_r   <= 1'b1;
        dn_wmask_r   <= bypass_s ? up_wmask   : wmask_mem_r[rd_ptr_r];
        dn_address_r <= bypass_s ? up_address : addr_mem_r[rd_ptr_r];
        dn_wdata_r   <= bypass_s ? up_wdata   : wdata_mem_r[rd_ptr_r];
      end else if (load_rd_s) begin
        dn_request_r <= 1'b1;
        dn_write_r   <= 1'b0;
        dn_wmask_r   <= up_wmask;
        dn_address_r <= up_address;
        dn_wdata_r   <= up_wdata;
      end else if (pop_s || rd_done_s) begin
        dn_request_r <= 1'b0;
      end
    end
  end

  assign up_ack     = up_ack_r;
  assign up_rdata   = up_rdata_r;
  assign dn_request = dn_request_r;
  assign dn_write   = dn_write_r;
  assign dn_wmask   = dn_wmask_r;
  assign dn_address = dn_address_r;
  assign dn_wdata   = dn_wdata_r;
  assign empty      = empty_r;
  assign count      = count_r;

endmodule
